// File: rtl/serial_alu_pkg.sv
// Shared types and constants for the bit-serial ALU: opcode and state encodings, default width.
package serial_alu_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice: full adder with SUB inversion of b, or bitwise AND/OR with zero carry out.
module serial_alu_bit
    import serial_alu_pkg::*;
(
    input  logic carry,
    input  logic a,
    input  logic b,
    input  op_t  op,
    output logic r,
    output logic cnext
);

    logic bi;

    always_comb begin
        bi    = b;
        r     = 1'b0;
        cnext = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                bi    = b ^ (op == OP_SUB);
                r     = a ^ bi ^ carry;
                cnext = (a & bi) | (carry & (a ^ bi));
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            default: r = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU (ADD/SUB/AND/OR), one bit per cycle LSB first.
// Define SERIAL_ALU_OVF_EN to add the signed-overflow output ovf.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o,
    output logic             cout
`ifdef SERIAL_ALU_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr, b_sr, r_sr;
    op_t              op_r;
    logic             accept, last, bit_r, bit_c;

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (cnt == CW'(WIDTH - 1));
    assign busy   = (state == S_SHIFT);
    assign done   = (state == S_DONE);

    serial_alu_bit u_bit (
        .carry (carry),
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .op    (op_r),
        .r     (bit_r),
        .cnext (bit_c)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_SHIFT;
            S_SHIFT: if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_SHIFT : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Result bits accumulate in r_sr so o only changes on the final shift cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            op_r  <= OP_ADD;
            o     <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= i0;
            b_sr  <= i1;
            op_r  <= op_t'(op);
            carry <= op[0];
            cnt   <= '0;
        end else if (state == S_SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= {bit_r, r_sr[WIDTH-1:1]};
            carry <= bit_c;
            cnt   <= last ? '0 : cnt + CW'(1);
            if (last) begin
                o    <= {bit_r, r_sr[WIDTH-1:1]};
                cout <= bit_c;
`ifdef SERIAL_ALU_OVF_EN
                ovf  <= (op_r == OP_ADD || op_r == OP_SUB) ? (carry ^ bit_c) : 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Directed self-checking bench for serial_alu (WIDTH=16); checks ovf when SERIAL_ALU_OVF_EN is defined.
module tb_serial_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] i0, i1;
    logic        busy, done, cout;
    logic [15:0] o;
`ifdef SERIAL_ALU_OVF_EN
    logic        ovf;
`endif

    int nerr   = 0;
    int nchk   = 0;
    int bcnt   = 0;
    int dat    = 0;

    serial_alu #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .i0    (i0),
        .i1    (i1),
        .busy  (busy),
        .done  (done),
        .o     (o),
        .cout  (cout)
`ifdef SERIAL_ALU_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present inputs, take the accepting edge, drop start, then count cycles until done (bounded).
    task automatic run_op(input logic [1:0] opc, input logic [15:0] a, input logic [15:0] b,
                          output int busy_cycles, output int done_cycle);
        @(negedge clk);
        start = 1'b1; op = opc; i0 = a; i1 = b;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cycles = 0;
        done_cycle  = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                done_cycle = c;
                break;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; i0 = '0; i1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_o", 32'(o), 32'h0);
        chk("rst_cout", 32'(cout), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);

        run_op(2'b00, 16'h1234, 16'h4321, bcnt, dat);
        chk("add1_o", 32'(o), 32'h5555);
        chk("add1_cout", 32'(cout), 32'h0);
        chk("add1_done_at", 32'(dat), 32'd17);
        chk("add1_busy_cycles", 32'(bcnt), 32'd16);

        run_op(2'b00, 16'hFFFF, 16'h0001, bcnt, dat);
        chk("add2_o", 32'(o), 32'h0000);
        chk("add2_cout", 32'(cout), 32'h1);
`ifdef SERIAL_ALU_OVF_EN
        chk("add2_ovf", 32'(ovf), 32'h0);
`endif

        run_op(2'b00, 16'h7FFF, 16'h0001, bcnt, dat);
        chk("add3_o", 32'(o), 32'h8000);
        chk("add3_cout", 32'(cout), 32'h0);
`ifdef SERIAL_ALU_OVF_EN
        chk("add3_ovf", 32'(ovf), 32'h1);
`endif

        run_op(2'b01, 16'h0005, 16'h0007, bcnt, dat);
        chk("sub1_o", 32'(o), 32'hFFFE);
        chk("sub1_cout", 32'(cout), 32'h0);
`ifdef SERIAL_ALU_OVF_EN
        chk("sub1_ovf", 32'(ovf), 32'h0);
`endif

        run_op(2'b01, 16'h0007, 16'h0005, bcnt, dat);
        chk("sub2_o", 32'(o), 32'h0002);
        chk("sub2_cout", 32'(cout), 32'h1);

        run_op(2'b10, 16'hF0F0, 16'h3C3C, bcnt, dat);
        chk("and_o", 32'(o), 32'h3030);
        chk("and_cout", 32'(cout), 32'h0);

        run_op(2'b11, 16'hF0F0, 16'h3C3C, bcnt, dat);
        chk("or_o", 32'(o), 32'hFCFC);
        chk("or_cout", 32'(cout), 32'h0);
`ifdef SERIAL_ALU_OVF_EN
        chk("or_ovf", 32'(ovf), 32'h0);
`endif

        // Held start: AND accepted, then operands switch to ADD 1+1 with start still high.
        @(negedge clk);
        start = 1'b1; op = 2'b10; i0 = 16'hF0F0; i1 = 16'h3C3C;
        @(posedge clk);
        #1 op = 2'b00; i0 = 16'h0001; i1 = 16'h0001;
        dat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 5) chk("hold_o_during_shift", 32'(o), 32'hFCFC);
            if (done) begin
                dat = c;
                break;
            end
        end
        chk("hold_done_at", 32'(dat), 32'd17);
        chk("hold_and_o", 32'(o), 32'h3030);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'h1);
        chk("b2b_done", 32'(done), 32'h0);
        chk("b2b_o_held", 32'(o), 32'h3030);
        dat = -1;
        for (int c = 2; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                dat = c;
                break;
            end
        end
        chk("b2b_done_at", 32'(dat), 32'd17);
        chk("b2b_o", 32'(o), 32'h0002);
        @(negedge clk);
        chk("b2b_no_queue_busy", 32'(busy), 32'h0);
        chk("b2b_no_queue_done", 32'(done), 32'h0);

        run_op(2'b01, 16'h0007, 16'h0005, bcnt, dat);
        chk("pre_rst_cout", 32'(cout), 32'h1);

        // Reset asserted mid-shift, checked before the next clock edge.
        @(negedge clk);
        start = 1'b1; op = 2'b00; i0 = 16'h1234; i1 = 16'h4321;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_o", 32'(o), 32'h0);
        chk("arst_cout", 32'(cout), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 32'(busy), 32'h0);

        run_op(2'b00, 16'h0001, 16'h0001, bcnt, dat);
        chk("post_rst_o", 32'(o), 32'h0002);
        chk("post_rst_done_at", 32'(dat), 32'd17);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
